// File: rtl/mem_lsu_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
//
// Handshake: the master raises dmem_req_o with we/be/addr/wdata and holds
// all of them stable until the slave answers with dmem_gnt_i in the same
// cycle; the transfer is accepted on that clock edge. For a load the slave
// later returns the word with a one-cycle dmem_rvalid_i pulse, never in the
// grant cycle itself.
//
// Signals:
//   dmem_req_o     master -> slave   request valid
//   dmem_we_o      master -> slave   1 = store, 0 = load
//   dmem_be_o      master -> slave   byte enables
//   dmem_addr_o    master -> slave   word-aligned address
//   dmem_wdata_o   master -> slave   lane-replicated store data
//   dmem_gnt_i     slave  -> master  request accepted
//   dmem_rvalid_i  slave  -> master  load data valid
//   dmem_rdata_i   slave  -> master  load word
interface mem_lsu_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM stage of the RV32I pipeline: load/store unit.
//
// Turns EX->MEM bundles into word-aligned data-memory transactions, aligns
// byte lanes, sign/zero-extends load data and stalls EX (ready_mem_o=0)
// while an access is outstanding. Non-memory ops reach WB one cycle later.
//
// Ports:
//   clk, rstl               clock, synchronous active-low reset
//   valid_exe_i             EX bundle valid
//   opcode_exe_2_mem_i      LH=0 LB=1 LW=2 LBU=3 LHU=4 SW=5 SH=6 SB=7, else non-memory
//   rd_exe_2_mem_i          destination register
//   rd_data_exe_2_mem_i     EX result for non-memory ops
//   mem_address_i           byte address
//   mem_data_i              store data, right-justified
//   ready_mem_o             stage can accept a bundle (1 only in IDLE)
//   dmem                    data-memory bus (master side)
//   wb_valid_o              writeback pulse
//   rd_mem_2_wb_o           writeback register
//   rd_data_mem_2_wb_o      writeback data
//   misalign_o              pulse: misaligned access dropped
//   err_o                   pulse: access aborted on timeout
//   state_o                 current FSM state (0=IDLE 1=REQ 2=WAIT), debug
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RD_W           = 11
) (
    input  logic              clk,
    input  logic              rstl,
    input  logic              valid_exe_i,
    input  logic [31:0]       opcode_exe_2_mem_i,
    input  logic [RD_W-1:0]   rd_exe_2_mem_i,
    input  logic [31:0]       rd_data_exe_2_mem_i,
    input  logic [31:0]       mem_address_i,
    input  logic [31:0]       mem_data_i,
    output logic              ready_mem_o,
    mem_lsu_if.master         dmem,
    output logic              wb_valid_o,
    output logic [RD_W-1:0]   rd_mem_2_wb_o,
    output logic [31:0]       rd_data_mem_2_wb_o,
    output logic              misalign_o,
    output logic              err_o,
    output logic [1:0]        state_o
);

    localparam logic [2:0] OP_LH  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Latched transaction
    logic [2:0]       op_q;
    logic [RD_W-1:0]  rd_q;
    logic [31:0]      addr_q;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;

    // Registered stage outputs
    logic             wb_valid_q;
    logic [RD_W-1:0]  wb_rd_q;
    logic [31:0]      wb_data_q;
    logic             misalign_q;
    logic             err_q;

    // Incoming-op decode
    logic       in_is_mem, in_is_byte, in_is_half, in_is_word, in_is_load, in_misaligned;
    logic [2:0] in_op;
    logic [3:0] st_be;
    logic [31:0] st_wdata;

    // Control strobes from the FSM
    logic pass_go, mem_go, misal_go, ld_done, timeout_go;

    // Load extraction
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign in_op      = opcode_exe_2_mem_i[2:0];
    // Opcodes 0..7 are memory ops; any set upper bit makes it a pass-through.
    assign in_is_mem  = (opcode_exe_2_mem_i[31:3] == 29'd0);
    assign in_is_byte = (in_op == OP_LB) || (in_op == OP_LBU) || (in_op == OP_SB);
    assign in_is_half = (in_op == OP_LH) || (in_op == OP_LHU) || (in_op == OP_SH);
    assign in_is_word = (in_op == OP_LW) || (in_op == OP_SW);
    assign in_is_load = (in_op <= OP_LHU);
    assign in_misaligned = (in_is_half && mem_address_i[0]) ||
                           (in_is_word && (mem_address_i[1:0] != 2'b00));

    // Store lane placement; loads always fetch the whole word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = mem_data_i;
        if (!in_is_load) begin
            if (in_is_byte) begin
                st_be    = 4'b0001 << mem_address_i[1:0];
                st_wdata = {4{mem_data_i[7:0]}};
            end else if (in_is_half) begin
                st_be    = mem_address_i[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{mem_data_i[15:0]}};
            end
        end
    end

    // Next-state logic and control strobes
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pass_go    = 1'b0;
        mem_go     = 1'b0;
        misal_go   = 1'b0;
        ld_done    = 1'b0;
        timeout_go = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_exe_i) begin
                    if (!in_is_mem) begin
                        pass_go = 1'b1;
                    end else if (in_misaligned) begin
                        misal_go = 1'b1;
                    end else begin
                        mem_go  = 1'b1;
                        state_d = S_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            S_REQ: begin
                if (dmem.dmem_gnt_i) begin
                    // Stores complete on grant; loads wait for rvalid.
                    state_d = we_q ? S_IDLE : S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LIMIT) begin
                    timeout_go = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (dmem.dmem_rvalid_i) begin
                    ld_done = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LIMIT) begin
                    timeout_go = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pick the addressed lane of the returned word and extend it.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = dmem.dmem_rdata_i[7:0];
            2'd1:    ld_byte = dmem.dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem.dmem_rdata_i[23:16];
            default: ld_byte = dmem.dmem_rdata_i[31:24];
        endcase
        ld_half = addr_q[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
        case (op_q)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem.dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstl) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= pass_go | ld_done;
            misalign_q <= misal_go;
            err_q      <= timeout_go;
            if (pass_go) begin
                wb_rd_q   <= rd_exe_2_mem_i;
                wb_data_q <= rd_data_exe_2_mem_i;
            end else if (ld_done) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= ld_data;
            end
            if (mem_go) begin
                op_q    <= in_op;
                rd_q    <= rd_exe_2_mem_i;
                addr_q  <= mem_address_i;
                we_q    <= !in_is_load;
                be_q    <= st_be;
                wdata_q <= st_wdata;
            end
        end
    end

    assign ready_mem_o        = (state_q == S_IDLE);
    assign dmem.dmem_req_o    = (state_q == S_REQ);
    assign dmem.dmem_we_o     = we_q;
    assign dmem.dmem_be_o     = be_q;
    assign dmem.dmem_addr_o   = {addr_q[31:2], 2'b00};
    assign dmem.dmem_wdata_o  = wdata_q;
    assign wb_valid_o         = wb_valid_q;
    assign rd_mem_2_wb_o      = wb_rd_q;
    assign rd_data_mem_2_wb_o = wb_data_q;
    assign misalign_o         = misalign_q;
    assign err_o              = err_q;
    assign state_o            = state_q;

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM stage of the RV32I pipeline; consumes the EX→MEM bundle: opcode, rd, rd result, store address, store data.
- Loads and stores are turned into word-aligned data-memory transactions using a req/gnt/rvalid handshake. Byte lanes are aligned, load data is sign- or zero-extended, and the pipeline is stalled while a transaction is outstanding.
- Non-memory ops pass through to WB with one-cycle latency.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in REQ or WAIT before the access is aborted with err_o.
- RD_W, 11: width of the destination register field. Matches the EX→MEM bundle.

Ports:
- clk  in  1  clock
- rstl  in  1  reset, synchronous, active-low
- valid_exe_i  in  1  EX bundle valid this cycle
- opcode_exe_2_mem_i  in  32  op code. LH=0, LB=1, LW=2, LBU=3, LHU=4, SW=5, SH=6, SB=7; any other value is non-memory.
- rd_exe_2_mem_i  in  RD_W  destination register
- rd_data_exe_2_mem_i  in  32  EX result; used for non-memory ops
- mem_address_i  in  32  byte address for load/store
- mem_data_i  in  32  store data, right-justified
- ready_mem_o  out  1  stage can accept a bundle (EX stalls when 0)
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1=store
- dmem_be_o  out  4  byte enables
- dmem_addr_o  out  32  {addr[31:2],2'b00}
- dmem_wdata_o  out  32  lane-shifted store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  32  load word
- wb_valid_o  out  1  writeback valid (1-cycle pulse)
- rd_mem_2_wb_o  out  RD_W  writeback register
- rd_data_mem_2_wb_o  out  32  writeback data
- misalign_o  out  1  1-cycle pulse: misaligned access dropped
- err_o  out  1  1-cycle pulse: timeout abort

Behaviour:
- **Reset** (rstl=0 at posedge): state=IDLE, timeout counter=0.
  - Outputs go to 0, except ready_mem_o=1 (it is combinational, 1 in IDLE).
  - Reset mid-transaction abandons the access: dmem_req_o=0 next cycle, and a later rvalid is ignored while in IDLE.
- **FSM states**: IDLE, REQ, WAIT. ready_mem_o=1 only in IDLE. A bundle is accepted only when valid_exe_i & ready_mem_o.
- **IDLE, non-memory op accepted**: next cycle wb_valid_o=1, rd/rd_data copied. Stay IDLE. Back-to-back ops give one per cycle.
- **Alignment check**:
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - On violation: no request, misalign_o=1 next cycle, no wb_valid_o, stay IDLE.
- **Aligned load/store accepted**:
  - Latch op, rd, address, data; go to REQ.
  - dmem_req_o/we/be/addr/wdata are driven from registers and held stable until gnt.
- **Byte enables and store data**:
  - Byte: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - Half: be=addr[1]?1100:0011, wdata={2{data[15:0]}}.
  - Word: be=1111, wdata=data.
  - Loads use be=1111, we=0.
- **REQ**: dmem_req_o=1. When gnt is high:
  - Store: wb_valid_o=0, go to IDLE next cycle.
  - Load: go to WAIT.
- **WAIT**: dmem_req_o=0. On rvalid:
  - Select the byte/half by latched addr[1:0] (byte lane addr[1:0]; half lane addr[1]).
  - Extension: sign-extend for LB/LH, zero-extend for LBU/LHU; LW takes the full word.
  - Next cycle: wb_valid_o=1 with rd and the extended data; state goes to IDLE.
  - rvalid in the same cycle as gnt is not allowed; the memory returns data ≥1 cycle after gnt.
- **Timeout**:
  - Counter clears on entry to REQ and on the REQ→WAIT transition, and increments each cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYCLES gives err_o=1 for one cycle, dmem_req_o drops, go to IDLE, no writeback.
- **Latency**:
  - Non-memory op: 1 cycle.
  - Store: accept→req in 1 cycle, done the cycle after gnt.
  - Load: rvalid + 1 cycle to wb_valid_o.
- wb_valid_o, misalign_o and err_o are never high in the same cycle.

Test Plan:
- Pass-through: ADD op=14, rd=5, data=0x1234 → next cycle wb_valid_o=1, rd=5, data=0x1234, no dmem_req_o.
- LB at 0x1003, rdata=0x80FF_FF00, gnt at cycle 1, rvalid at cycle 3 → be=1111, addr=0x1000, wb data=0xFFFF_FF80. ready_mem_o=0 until return to IDLE.
- LHU at 0x2002, rdata=0x8001_0000 → wb data=0x0000_8001. LH at the same address with the same rdata → 0xFFFF_8001.
- SB at 0x3001, data=0xAB; gnt held low 4 cycles → req/addr=0x3000/be=0010/wdata=0xABABABAB stable all 4 cycles; no wb_valid_o.
- SH at 0x4001 → misalign_o=1 one cycle, no request. An LW at 0x4000 that never receives gnt → err_o after TIMEOUT_CYCLES, then IDLE.
- Assert rstl=0 while in WAIT, then pulse rvalid after reset → state IDLE, no wb_valid_o, ready_mem_o=1.
